rv_decode_stage: RTL and testbench
==================================

Name: rv_decode_stage

Overview:
- Parametrised instruction-decode pipeline stage between fetch and execute.
- Accepts instruction/PC beats over a valid/ready handshake and registers fully decoded fields: class one-hot, register indices, funct fields, sign-extended immediate and illegal flag.
- Supports RV32I/RV64I datapaths (XLEN) and RV32E-style reduced register files (REGISTER_COUNT).
- Contains a two-entry skid buffer, so in_ready is a registered signal and never depends combinationally on out_ready.

Parameters:
XLEN, 32, datapath width; immediate and PC width; legal values 32 or 64
REGISTER_COUNT, 32, architectural register count; 16 or 32; a register index >= REGISTER_COUNT is illegal
INSTRUCTION_WIDTH, 32, fetched instruction width; fixed at 32 (no compressed support)

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous pipeline flush (branch redirect)
in_valid  in  1  fetch beat valid
in_ready  out  1  stage can accept a beat
in_instr  in  32  raw instruction
in_pc  in  XLEN  instruction address
out_valid  out  1  decoded beat valid
out_ready  in  1  execute accepts beat
out_pc  out  XLEN  PC of decoded instruction
out_class  out  7  one-hot class: [0]OP_IMM [1]OP [2]LOAD [3]STORE [4]BRANCH [5]JAL [6]JALR
out_rd  out  5  destination register; forced to 0 for STORE and BRANCH
out_rs1  out  5  source register 1; forced to 0 for JAL
out_rs2  out  5  source register 2; valid for OP, STORE and BRANCH, otherwise 0
out_funct3  out  3  instr[14:12]
out_funct7  out  7  instr[31:25]
out_imm  out  XLEN  sign-extended immediate (I/S/B/J format by class); 0 for OP
out_illegal  out  1  unknown opcode, instr[1:0] != 2'b11, or register index out of range

Behaviour:
- Clocking and reset: single clock domain. While rst_n is low, out_valid=0, in_ready=0 and all data outputs=0. The first clk edge after rst_n rises sets in_ready=1.
- Decode: purely combinational from in_instr, registered on acceptance. Latency is 1 cycle: a beat accepted on edge N appears with out_valid=1 after edge N.
- Immediate formats:
  - I (OP_IMM, LOAD, JALR): instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}.
  - All formats sign-extended from the top instruction bit to XLEN.
- Illegal beats: still passed downstream with out_illegal=1 and out_class=0; the other fields carry raw extractions. Range check applies only to indices used by the decoded class.
- Handshake: a transfer occurs on any edge where valid and ready are both high. out_valid, once asserted, holds with stable data until out_ready. Upstream may drop in_valid at any time.
- Skid state machine (main register M, skid register S):
  - EMPTY: in_ready=1, out_valid=0. Accept -> ONE.
  - ONE: out_valid=1, in_ready=1.
    - Accept with out_ready=1: M is replaced, stay ONE.
    - Accept with out_ready=0: beat goes to S -> FULL.
    - out_ready=1 with no accept -> EMPTY.
  - FULL: in_ready=0. out_ready=1: S moves to M -> ONE.
- Throughput: 1 beat per cycle while out_ready stays high. in_ready deasserts one cycle after the stall that fills S.
- flush: at the next edge, M and S are invalidated, state -> EMPTY, in_valid is ignored that cycle, out_valid=0. Flush takes priority over all simultaneous handshakes, including a transfer on the same edge; that beat counts as consumed downstream.
- Reset mid-operation: pending beats are discarded immediately (asynchronous), with no partial output.

Test Plan:
- Reset and single beat: rst_n low 3 cycles, then in_instr=0x00500093 (addi x1,x0,5), pc=0x100 -> out_valid after 1 edge, class[0]=1, rd=1, rs1=0, imm=5, out_pc=0x100, illegal=0.
- Immediate formats:
  - 0x0020A423 (sw x2,8(x1)) -> class[3], rd=0, rs1=1, rs2=2, imm=8.
  - 0xFE000EE3 (beq x0,x0,-4) -> class[4], imm=0xFFFFFFFC (XLEN=32), 0xFFFFFFFFFFFFFFFC (XLEN=64).
  - 0x008000EF (jal x1,8) -> class[5], rd=1, imm=8.
- Backpressure: stream 4 beats while holding out_ready low from the 2nd edge -> in_ready=0 after S fills; release -> beats arrive in order, no loss or duplication, then 1 beat/cycle.
- Illegal detection:
  - 0x00000000 -> illegal=1, class=0.
  - REGISTER_COUNT=16 with 0x01000893 (addi x17,x0,16) -> illegal=1.
  - Same instruction with REGISTER_COUNT=32 -> legal.
- Flush while FULL with out_ready=1 and in_valid=1 -> out_valid=0 next cycle, in_ready=1, the in_valid beat is dropped, no stale beat appears later.
- Async reset asserted mid-stream between edges -> outputs go to 0 immediately; the first beat after release decodes correctly.

Source files
------------

// File: rtl/rv_decode_stage.sv
// rv_decode_stage
// Instruction-decode pipeline stage sitting between fetch and execute.
// Each accepted fetch beat (instruction + PC) is decoded combinationally and
// captured into a two-entry skid buffer, so the execute side sees fully
// decoded fields one cycle after acceptance and in_ready is purely registered.
//
// Ports
//   clk, rst_n      : clock (rising edge) and asynchronous active-low reset
//   flush           : synchronous flush, empties the stage at the next edge
//   in_valid/ready  : fetch-side handshake
//   in_instr, in_pc : raw 32-bit instruction and its XLEN-bit address
//   out_valid/ready : execute-side handshake
//   out_pc          : PC of the decoded instruction
//   out_class       : one-hot [0]OP_IMM [1]OP [2]LOAD [3]STORE [4]BRANCH [5]JAL [6]JALR
//   out_rd/rs1/rs2  : register indices, zeroed where the class does not use them
//   out_funct3/7    : raw funct fields
//   out_imm         : sign-extended immediate in the format implied by the class
//   out_illegal     : unknown opcode, non-32-bit encoding or register out of range
module rv_decode_stage #(
    parameter int XLEN              = 32,
    parameter int REGISTER_COUNT    = 32,
    parameter int INSTRUCTION_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [INSTRUCTION_WIDTH-1:0] in_instr,
    input  logic [XLEN-1:0]              in_pc,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [XLEN-1:0]              out_pc,
    output logic [6:0]                   out_class,
    output logic [4:0]                   out_rd,
    output logic [4:0]                   out_rs1,
    output logic [4:0]                   out_rs2,
    output logic [2:0]                   out_funct3,
    output logic [6:0]                   out_funct7,
    output logic [XLEN-1:0]              out_imm,
    output logic                         out_illegal
);

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [6:0]      cls;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [XLEN-1:0] imm;
        logic            illegal;
    } beat_t;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_ONE,
        ST_FULL
    } state_t;

    logic [6:0]      w_known;
    logic [4:0]      w_rd;
    logic [4:0]      w_rs1;
    logic [4:0]      w_rs2;
    logic            w_uses_rd;
    logic            w_uses_rs1;
    logic            w_uses_rs2;
    logic            w_rd_bad;
    logic            w_rs1_bad;
    logic            w_rs2_bad;
    logic            w_illegal;
    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_imm_s;
    logic [XLEN-1:0] w_imm_b;
    logic [XLEN-1:0] w_imm_j;
    beat_t           w_dec;

    state_t          r_state;
    state_t          w_next_state;
    logic            r_in_ready;
    beat_t           r_main;
    beat_t           r_skid;
    logic            w_accept;
    logic            w_load_main;
    logic            w_main_from_skid;
    logic            w_load_skid;

    assign w_rd  = in_instr[11:7];
    assign w_rs1 = in_instr[19:15];
    assign w_rs2 = in_instr[24:20];

    assign w_imm_i = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
    assign w_imm_s = {{(XLEN-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign w_imm_b = {{(XLEN-13){in_instr[31]}}, in_instr[31], in_instr[7],
                      in_instr[30:25], in_instr[11:8], 1'b0};
    assign w_imm_j = {{(XLEN-21){in_instr[31]}}, in_instr[31], in_instr[19:12],
                      in_instr[20], in_instr[30:21], 1'b0};

    // Opcode to candidate class, before any legality checks.
    always_comb begin
        w_known = 7'b0;
        case (in_instr[6:0])
            OPC_OP_IMM: w_known = 7'b0000001;
            OPC_OP:     w_known = 7'b0000010;
            OPC_LOAD:   w_known = 7'b0000100;
            OPC_STORE:  w_known = 7'b0001000;
            OPC_BRANCH: w_known = 7'b0010000;
            OPC_JAL:    w_known = 7'b0100000;
            OPC_JALR:   w_known = 7'b1000000;
            default:    w_known = 7'b0;
        endcase
    end

    // Only the register fields the class actually reads or writes are range checked.
    assign w_uses_rd  = |(w_known & 7'b1100111);
    assign w_uses_rs1 = |(w_known & 7'b1011111);
    assign w_uses_rs2 = |(w_known & 7'b0011010);

    assign w_rd_bad  = ({27'd0, w_rd}  >= 32'(REGISTER_COUNT));
    assign w_rs1_bad = ({27'd0, w_rs1} >= 32'(REGISTER_COUNT));
    assign w_rs2_bad = ({27'd0, w_rs2} >= 32'(REGISTER_COUNT));

    assign w_illegal = (in_instr[1:0] != 2'b11) || (w_known == 7'b0)
                     || (w_uses_rd && w_rd_bad) || (w_uses_rs1 && w_rs1_bad)
                     || (w_uses_rs2 && w_rs2_bad);

    // Illegal beats keep the raw register fields and an I-format immediate so
    // the trap handler downstream can still inspect the encoding.
    always_comb begin
        w_dec        = '0;
        w_dec.pc     = in_pc;
        w_dec.funct3 = in_instr[14:12];
        w_dec.funct7 = in_instr[31:25];
        if (w_illegal) begin
            w_dec.illegal = 1'b1;
            w_dec.rd      = w_rd;
            w_dec.rs1     = w_rs1;
            w_dec.rs2     = w_rs2;
            w_dec.imm     = w_imm_i;
        end else begin
            w_dec.cls = w_known;
            w_dec.rd  = w_uses_rd  ? w_rd  : 5'd0;
            w_dec.rs1 = w_uses_rs1 ? w_rs1 : 5'd0;
            w_dec.rs2 = w_uses_rs2 ? w_rs2 : 5'd0;
            if (w_known[3]) begin
                w_dec.imm = w_imm_s;
            end else if (w_known[4]) begin
                w_dec.imm = w_imm_b;
            end else if (w_known[5]) begin
                w_dec.imm = w_imm_j;
            end else if (w_known[1]) begin
                w_dec.imm = '0;
            end else begin
                w_dec.imm = w_imm_i;
            end
        end
    end

    assign w_accept = in_valid && r_in_ready;

    // Skid control: M holds the beat presented downstream, S catches the beat
    // accepted during a stall. Flush wins over every handshake on the same edge.
    always_comb begin
        w_next_state     = r_state;
        w_load_main      = 1'b0;
        w_main_from_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (flush) begin
            w_next_state = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_load_main  = 1'b1;
                        w_next_state = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_accept && out_ready) begin
                        w_load_main = 1'b1;
                    end else if (w_accept) begin
                        w_load_skid  = 1'b1;
                        w_next_state = ST_FULL;
                    end else if (out_ready) begin
                        w_next_state = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (out_ready) begin
                        w_load_main      = 1'b1;
                        w_main_from_skid = 1'b1;
                        w_next_state     = ST_ONE;
                    end
                end
                default: w_next_state = ST_EMPTY;
            endcase
        end
    end

    // in_ready is registered from the next state, which is what keeps it free
    // of any combinational path from out_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b0;
            r_main     <= '0;
            r_skid     <= '0;
        end else begin
            r_state    <= w_next_state;
            r_in_ready <= (w_next_state != ST_FULL);
            if (w_load_main) begin
                r_main <= w_main_from_skid ? r_skid : w_dec;
            end
            if (w_load_skid) begin
                r_skid <= w_dec;
            end
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = (r_state != ST_EMPTY);
    assign out_pc      = r_main.pc;
    assign out_class   = r_main.cls;
    assign out_rd      = r_main.rd;
    assign out_rs1     = r_main.rs1;
    assign out_rs2     = r_main.rs2;
    assign out_funct3  = r_main.funct3;
    assign out_funct7  = r_main.funct7;
    assign out_imm     = r_main.imm;
    assign out_illegal = r_main.illegal;

endmodule

// File: tb/tb_rv_decode_stage.sv
// tb_rv_decode_stage
// Drives two decode stages in lockstep: an RV32I build (XLEN=32, 32 registers)
// and an RV64E-style build (XLEN=64, 16 registers). Expected outputs come from
// a queue holding the raw beats currently inside the stage and a decoder
// written from the instruction-format arithmetic.
`timescale 1ns/1ps
module tb_rv_decode_stage;

    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
    } beat_t;

    logic        clk = 1'b0;
    logic        rstN;
    logic        flush;
    logic        inValid;
    logic [31:0] inInstr;
    logic [63:0] inPc;
    logic        outReady;

    logic        aInReady, aOutValid, aOutIllegal;
    logic [31:0] aOutPc, aOutImm;
    logic [6:0]  aOutClass, aOutFunct7;
    logic [4:0]  aOutRd, aOutRs1, aOutRs2;
    logic [2:0]  aOutFunct3;

    logic        bInReady, bOutValid, bOutIllegal;
    logic [63:0] bOutPc, bOutImm;
    logic [6:0]  bOutClass, bOutFunct7;
    logic [4:0]  bOutRd, bOutRs1, bOutRs2;
    logic [2:0]  bOutFunct3;

    beat_t pending[$];
    bit    rstDone;
    bit    lastAccepted;
    int    checkCount;
    int    failCount;

    always #5 clk = ~clk;

    rv_decode_stage #(.XLEN(32), .REGISTER_COUNT(32), .INSTRUCTION_WIDTH(32)) dutA (
        .clk(clk), .rst_n(rstN), .flush(flush),
        .in_valid(inValid), .in_ready(aInReady), .in_instr(inInstr), .in_pc(inPc[31:0]),
        .out_valid(aOutValid), .out_ready(outReady), .out_pc(aOutPc), .out_class(aOutClass),
        .out_rd(aOutRd), .out_rs1(aOutRs1), .out_rs2(aOutRs2), .out_funct3(aOutFunct3),
        .out_funct7(aOutFunct7), .out_imm(aOutImm), .out_illegal(aOutIllegal)
    );

    rv_decode_stage #(.XLEN(64), .REGISTER_COUNT(16), .INSTRUCTION_WIDTH(32)) dutB (
        .clk(clk), .rst_n(rstN), .flush(flush),
        .in_valid(inValid), .in_ready(bInReady), .in_instr(inInstr), .in_pc(inPc),
        .out_valid(bOutValid), .out_ready(outReady), .out_pc(bOutPc), .out_class(bOutClass),
        .out_rd(bOutRd), .out_rs1(bOutRs1), .out_rs2(bOutRs2), .out_funct3(bOutFunct3),
        .out_funct7(bOutFunct7), .out_imm(bOutImm), .out_illegal(bOutIllegal)
    );

    // Single comparison point: counts every check and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [191:0] observed,
                               input logic [191:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [191:0] packA();
        return {95'd0, aOutPc, aOutClass, aOutRd, aOutRs1, aOutRs2, aOutFunct3,
                aOutFunct7, aOutImm, aOutIllegal};
    endfunction

    function automatic logic [191:0] packB();
        return {31'd0, bOutPc, bOutClass, bOutRd, bOutRs1, bOutRs2, bOutFunct3,
                bOutFunct7, bOutImm, bOutIllegal};
    endfunction

    // Reference decoder: immediates are rebuilt as weighted sums of instruction
    // fields, with the top instruction bit carrying the negative weight.
    function automatic logic [191:0] expectBeat(input beat_t b, input int xlen, input int rc);
        logic [31:0] ins;
        logic [6:0]  opTable [7];
        int          k;
        bit          usesRd, usesRs1, usesRs2, ill;
        longint      immI, immS, immB, immJ, imm;
        logic [63:0] immBits;
        logic [6:0]  cls;
        logic [4:0]  rd, rs1, rs2;
        ins     = b.instr;
        opTable = '{7'h13, 7'h33, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67};
        k = -1;
        for (int i = 0; i < 7; i++) begin
            if (ins[6:0] == opTable[i]) k = i;
        end
        usesRd  = (k == 0) || (k == 1) || (k == 2) || (k == 5) || (k == 6);
        usesRs1 = (k >= 0) && (k != 5);
        usesRs2 = (k == 1) || (k == 3) || (k == 4);
        ill = (ins[1:0] != 2'b11) || (k < 0)
            || (usesRd  && int'(ins[11:7])  >= rc)
            || (usesRs1 && int'(ins[19:15]) >= rc)
            || (usesRs2 && int'(ins[24:20]) >= rc);
        immI = longint'(ins[31:20]) - (ins[31] ? 4096 : 0);
        immS = longint'({ins[31:25], ins[11:7]}) - (ins[31] ? 4096 : 0);
        immB = longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2
             + longint'(ins[7]) * 2048 - (ins[31] ? 4096 : 0);
        immJ = longint'(ins[30:21]) * 2 + longint'(ins[20]) * 2048
             + longint'(ins[19:12]) * 4096 - (ins[31] ? 1048576 : 0);
        cls = '0;
        if (ill) begin
            imm = immI;
            rd  = ins[11:7];
            rs1 = ins[19:15];
            rs2 = ins[24:20];
        end else begin
            cls[k] = 1'b1;
            rd  = usesRd  ? ins[11:7]  : 5'd0;
            rs1 = usesRs1 ? ins[19:15] : 5'd0;
            rs2 = usesRs2 ? ins[24:20] : 5'd0;
            case (k)
                1:       imm = 0;
                3:       imm = immS;
                4:       imm = immB;
                5:       imm = immJ;
                default: imm = immI;
            endcase
        end
        immBits = imm;
        if (xlen == 32) begin
            return {95'd0, b.pc[31:0], cls, rd, rs1, rs2, ins[14:12], ins[31:25],
                    immBits[31:0], ill};
        end
        return {31'd0, b.pc, cls, rd, rs1, rs2, ins[14:12], ins[31:25], immBits, ill};
    endfunction

    // Mix of every legal opcode plus junk; half the time registers are kept
    // below 16 so the reduced register file also sees legal traffic.
    function automatic logic [31:0] randInstr();
        logic [31:0] r;
        logic [6:0]  ops [7];
        int          sel;
        ops = '{7'h13, 7'h33, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67};
        r   = $urandom;
        sel = $urandom_range(0, 8);
        if (sel < 7) r[6:0] = ops[sel];
        if ($urandom_range(0, 1) == 1) begin
            r[11] = 1'b0;
            r[19] = 1'b0;
            r[24] = 1'b0;
        end
        return r;
    endfunction

    // Queue view of the stage at each rising edge.
    task automatic modelEdge();
        bit    expReady;
        bit    expValid;
        beat_t nb;
        lastAccepted = 1'b0;
        if (!rstN) return;
        expReady = rstDone && (pending.size() < 2);
        expValid = (pending.size() > 0);
        if (flush) begin
            pending.delete();
        end else begin
            if (expValid && outReady) void'(pending.pop_front());
            if (inValid && expReady) begin
                nb.instr = inInstr;
                nb.pc    = inPc;
                pending.push_back(nb);
                lastAccepted = 1'b1;
            end
        end
        rstDone = 1'b1;
    endtask

    task automatic checkCycle(input string tag);
        bit expReady;
        bit expValid;
        expReady = rstN && rstDone && (pending.size() < 2);
        expValid = (pending.size() > 0);
        checkOutput({tag, ".A.in_ready"},  192'(aInReady),  192'(expReady));
        checkOutput({tag, ".A.out_valid"}, 192'(aOutValid), 192'(expValid));
        checkOutput({tag, ".B.in_ready"},  192'(bInReady),  192'(expReady));
        checkOutput({tag, ".B.out_valid"}, 192'(bOutValid), 192'(expValid));
        if (expValid) begin
            checkOutput({tag, ".A.beat"}, packA(), expectBeat(pending[0], 32, 32));
            checkOutput({tag, ".B.beat"}, packB(), expectBeat(pending[0], 64, 16));
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, ".A.in_ready"},  192'(aInReady),  192'(0));
        checkOutput({tag, ".A.out_valid"}, 192'(aOutValid), 192'(0));
        checkOutput({tag, ".A.data"},      packA(),         192'(0));
        checkOutput({tag, ".B.in_ready"},  192'(bInReady),  192'(0));
        checkOutput({tag, ".B.out_valid"}, 192'(bOutValid), 192'(0));
        checkOutput({tag, ".B.data"},      packB(),         192'(0));
    endtask

    // One clock: drive inputs, take the edge, then sample 1 ns later.
    task automatic applyStimulus(input logic v, input logic [31:0] instr, input logic [63:0] pc,
                                 input logic ordy, input logic fl, input string tag);
        inValid  = v;
        inInstr  = instr;
        inPc     = pc;
        outReady = ordy;
        flush    = fl;
        @(posedge clk);
        modelEdge();
        #1;
        checkCycle(tag);
    endtask

    task automatic drain();
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'd0, 64'd0, 1'b1, 1'b0, "drain");
    endtask

    task automatic directBeat(input logic [31:0] instr, input logic [63:0] pc, input string tag);
        drain();
        applyStimulus(1'b1, instr, pc, 1'b1, 1'b0, tag);
    endtask

    initial begin
        logic [31:0] bpInstr [4];
        int          idx;
        checkCount = 0;
        failCount  = 0;
        rstDone    = 1'b0;
        rstN       = 1'b1;
        flush      = 1'b0;
        inValid    = 1'b0;
        inInstr    = '0;
        inPc       = '0;
        outReady   = 1'b0;
        #1 rstN = 1'b0;
        #1 checkResetOutputs("reset");
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'd0, 64'd0, 1'b0, 1'b0, "in_reset");
        rstN = 1'b1;
        applyStimulus(1'b0, 32'd0, 64'd0, 1'b0, 1'b0, "post_reset");
        checkOutput("first_in_ready", 192'(aInReady), 192'(1));

        // addi x1,x0,5
        directBeat(32'h00500093, 64'h100, "addi");
        checkOutput("addi.class", 192'(aOutClass), 192'(7'b0000001));
        checkOutput("addi.rd",    192'(aOutRd),    192'(1));
        checkOutput("addi.rs1",   192'(aOutRs1),   192'(0));
        checkOutput("addi.imm",   192'(aOutImm),   192'(5));
        checkOutput("addi.pc",    192'(aOutPc),    192'(32'h100));
        checkOutput("addi.ill",   192'(aOutIllegal), 192'(0));

        // sw x2,8(x1)
        directBeat(32'h0020A423, 64'h104, "sw");
        checkOutput("sw.class", 192'(aOutClass), 192'(7'b0001000));
        checkOutput("sw.rd",    192'(aOutRd),    192'(0));
        checkOutput("sw.rs1",   192'(aOutRs1),   192'(1));
        checkOutput("sw.rs2",   192'(aOutRs2),   192'(2));
        checkOutput("sw.imm",   192'(aOutImm),   192'(8));

        // beq x0,x0,-4
        directBeat(32'hFE000EE3, 64'h108, "beq");
        checkOutput("beq.class",  192'(aOutClass), 192'(7'b0010000));
        checkOutput("beq.imm32",  192'(aOutImm),   192'(32'hFFFFFFFC));
        checkOutput("beq.imm64",  192'(bOutImm),   192'(64'hFFFFFFFFFFFFFFFC));

        // jal x1,8
        directBeat(32'h008000EF, 64'h10C, "jal");
        checkOutput("jal.class", 192'(aOutClass), 192'(7'b0100000));
        checkOutput("jal.rd",    192'(aOutRd),    192'(1));
        checkOutput("jal.imm",   192'(aOutImm),   192'(8));

        directBeat(32'h00000000, 64'h110, "zero");
        checkOutput("zero.ill",   192'(aOutIllegal), 192'(1));
        checkOutput("zero.class", 192'(aOutClass),   192'(0));

        // addi x17,x0,16: legal with 32 registers, illegal with 16
        directBeat(32'h01000893, 64'h114, "x17");
        checkOutput("x17.ill_rc16", 192'(bOutIllegal), 192'(1));
        checkOutput("x17.ill_rc32", 192'(aOutIllegal), 192'(0));

        // Backpressure: four beats, out_ready low from the second edge.
        drain();
        bpInstr = '{32'h00100093, 32'h00200113, 32'h00300193, 32'h00400213};
        idx = 0;
        for (int c = 0; c < 30 && !(idx == 4 && pending.size() == 0); c++) begin
            applyStimulus(idx < 4, bpInstr[idx < 4 ? idx : 0], 64'h200 + 64'(4 * idx),
                          !(c >= 1 && c < 5), 1'b0, "bp");
            if (lastAccepted) idx++;
            if (c == 1 || c == 2) checkOutput("bp.in_ready_low", 192'(aInReady), 192'(0));
        end
        checkOutput("bp.all_delivered", 192'(idx), 192'(4));
        checkOutput("bp.queue_empty",   192'(pending.size()), 192'(0));

        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, randInstr(), {$urandom, $urandom}, 1'b1, 1'b0, "thru");
            checkOutput("thru.in_ready",  192'(aInReady),  192'(1));
            checkOutput("thru.out_valid", 192'(aOutValid), 192'(1));
        end

        // Flush while FULL with a simultaneous transfer and a new beat offered.
        drain();
        applyStimulus(1'b1, 32'h00100093, 64'h300, 1'b0, 1'b0, "fill");
        applyStimulus(1'b1, 32'h00200113, 64'h304, 1'b0, 1'b0, "fill");
        checkOutput("flush.full", 192'(aInReady), 192'(0));
        applyStimulus(1'b1, 32'h00300193, 64'h308, 1'b1, 1'b1, "flush");
        checkOutput("flush.out_valid", 192'(aOutValid), 192'(0));
        checkOutput("flush.in_ready",  192'(aInReady),  192'(1));
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 32'd0, 64'd0, 1'b1, 1'b0, "post_flush");
            checkOutput("flush.no_stale", 192'(aOutValid), 192'(0));
        end

        // Asynchronous reset between edges while the stage is full.
        applyStimulus(1'b1, 32'h00100093, 64'h400, 1'b0, 1'b0, "pre_arst");
        applyStimulus(1'b1, 32'h00200113, 64'h404, 1'b0, 1'b0, "pre_arst");
        #3;
        rstN = 1'b0;
        pending.delete();
        rstDone = 1'b0;
        #1 checkResetOutputs("arst");
        for (int i = 0; i < 2; i++) applyStimulus(1'b1, 32'h00500093, 64'h500, 1'b1, 1'b0, "arst_hold");
        rstN = 1'b1;
        applyStimulus(1'b1, 32'h00500093, 64'h500, 1'b1, 1'b0, "arst_release");
        applyStimulus(1'b1, 32'h00500093, 64'h500, 1'b1, 1'b0, "arst_beat");
        checkOutput("arst.rd",  192'(aOutRd),  192'(1));
        checkOutput("arst.imm", 192'(aOutImm), 192'(5));
        checkOutput("arst.pc",  192'(aOutPc),  192'(32'h500));

        // Randomised traffic with occasional flushes.
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 9) < 7, randInstr(), {$urandom, $urandom},
                          $urandom_range(0, 9) < 6, $urandom_range(0, 29) == 0, "rand");
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
